// File: rtl/blink_decoder.sv
// Recovers the blink speed (fast/slow) and blink presence from a sampled LED drive waveform
// by measuring rise-to-rise periods and locking after two agreeing classifications.
module blink_decoder #(
  parameter int FAST_PERIOD = 20000,
  parameter int SLOW_PERIOD = 200000,
  parameter int TOL_SHIFT   = 3,
  parameter int TIMEOUT     = 400000,
  parameter int CNT_W       = 20
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_led_drive,
  output logic             o_active,
  output logic             o_valid,
  output logic             o_speed,
  output logic [CNT_W-1:0] o_period,
  output logic             o_error
);

  localparam int W1 = CNT_W + 1;
  localparam logic [W1-1:0] FAST_LO = W1'(FAST_PERIOD - (FAST_PERIOD >> TOL_SHIFT));
  localparam logic [W1-1:0] FAST_HI = W1'(FAST_PERIOD + (FAST_PERIOD >> TOL_SHIFT));
  localparam logic [W1-1:0] SLOW_LO = W1'(SLOW_PERIOD - (SLOW_PERIOD >> TOL_SHIFT));
  localparam logic [W1-1:0] SLOW_HI = W1'(SLOW_PERIOD + (SLOW_PERIOD >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARMED, CONFIRM, LOCKED} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             active_reg, active_next;
  logic             valid_reg, valid_next;
  logic             speed_reg, speed_next;
  logic             cand_reg, cand_next;
  logic             error_reg, error_next;
  logic [CNT_W-1:0] period_reg, period_next;

  logic          rise;
  logic [W1-1:0] period_ext;
  logic          is_fast, is_slow, cls_ok, timeout;

  // sync_reg[1:0] is the two-flop synchronizer, sync_reg[2] the edge-detect delay
  assign rise       = sync_reg[1] & ~sync_reg[2];
  assign period_ext = {1'b0, cnt_reg};
  assign is_fast    = (period_ext >= FAST_LO) && (period_ext <= FAST_HI);
  assign is_slow    = !is_fast && (period_ext >= SLOW_LO) && (period_ext <= SLOW_HI);
  assign cls_ok     = is_fast | is_slow;
  // A rise on the saturation cycle takes priority over the timeout
  assign timeout    = (cnt_reg == TIMEOUT_C) && (state_reg != IDLE) && !rise;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync_reg   <= '0;
      cnt_reg    <= '0;
      state_reg  <= IDLE;
      active_reg <= 1'b0;
      valid_reg  <= 1'b0;
      speed_reg  <= 1'b0;
      cand_reg   <= 1'b0;
      error_reg  <= 1'b0;
      period_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], i_led_drive};
      if (rise)
        cnt_reg <= CNT_W'(1);
      else if (cnt_reg != TIMEOUT_C)
        cnt_reg <= cnt_reg + CNT_W'(1);
      state_reg  <= state_next;
      active_reg <= active_next;
      valid_reg  <= valid_next;
      speed_reg  <= speed_next;
      cand_reg   <= cand_next;
      error_reg  <= error_next;
      period_reg <= period_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    active_next = active_reg;
    valid_next  = valid_reg;
    speed_next  = speed_reg;
    cand_next   = cand_reg;
    period_next = period_reg;
    error_next  = 1'b0;
    if (rise) begin
      // The first rise after IDLE is only a reference, not a period
      if (state_reg != IDLE)
        period_next = cnt_reg;
      case (state_reg)
        IDLE: begin
          state_next  = ARMED;
          active_next = 1'b1;
        end
        ARMED: begin
          if (cls_ok) begin
            cand_next  = is_fast;
            state_next = CONFIRM;
          end else begin
            error_next = 1'b1;
          end
        end
        CONFIRM: begin
          if (!cls_ok) begin
            error_next = 1'b1;
            state_next = ARMED;
          end else if (is_fast == cand_reg) begin
            state_next = LOCKED;
            valid_next = 1'b1;
            speed_next = is_fast;
          end else begin
            cand_next = is_fast;
          end
        end
        LOCKED: begin
          if (!cls_ok) begin
            error_next = 1'b1;
            valid_next = 1'b0;
            state_next = ARMED;
          end else if (is_fast != cand_reg) begin
            valid_next = 1'b0;
            cand_next  = is_fast;
            state_next = CONFIRM;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      active_next = 1'b0;
      valid_next  = 1'b0;
      state_next  = IDLE;
    end
  end

  assign o_active = active_reg;
  assign o_valid  = valid_reg;
  assign o_speed  = speed_reg;
  assign o_period = period_reg;
  assign o_error  = error_reg;

endmodule

// File: tb/tb_blink_decoder.sv
// Bench for blink_decoder: a run-length reference model checked every cycle, directed
// scenarios with literal expectations, then randomized blink periods.
module tb_blink_decoder;
  localparam int FP = 20;
  localparam int SP = 200;
  localparam int TS = 2;
  localparam int TO = 400;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          led = 1'b0;
  logic          active, valid, speed, err;
  logic [CW-1:0] period;

  int checks = 0;
  int failures = 0;

  blink_decoder #(.FAST_PERIOD(FP), .SLOW_PERIOD(SP), .TOL_SHIFT(TS), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .i_clock(clk), .i_reset(rst), .i_led_drive(led),
    .o_active(active), .o_valid(valid), .o_speed(speed), .o_period(period), .o_error(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 = bad, 1 = fast, 2 = slow, from absolute distance to the nominal periods
  function automatic int classify(input int p);
    int df, ds;
    df = (p > FP) ? p - FP : FP - p;
    ds = (p > SP) ? p - SP : SP - p;
    if (df <= (FP >> TS)) return 1;
    if (ds <= (SP >> TS)) return 2;
    return 0;
  endfunction

  // Reference model: lock = at least two consecutive identical good periods since the
  // last reference rise; a BAD period or a timeout restarts the run.
  int cyc = 0, last_rise = 0, run_len = 0, run_cls = 0, m_period = 0, cls, p;
  bit m_active = 0, m_valid = 0, m_speed = 0, m_error = 0;
  bit s1 = 0, s2 = 0, s3 = 0; // pin samples taken 1, 2 and 3 edges ago
  bit m_rise;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      {s1, s2, s3} = 3'b000;
      {m_active, m_valid, m_speed, m_error} = 4'b0000;
      m_period = 0; run_len = 0; run_cls = 0;
    end else begin
      // detection happens on the third edge that sees the pin high
      m_rise = s2 && !s3;
      m_error = 0;
      if (m_rise) begin
        if (!m_active) begin
          m_active = 1;
          run_len = 0;
        end else begin
          p = cyc - last_rise;
          if (p > TO) p = TO;
          m_period = p;
          cls = classify(p);
          if (cls == 0) begin
            m_error = 1;
            run_len = 0;
          end else if (run_len > 0 && cls == run_cls) begin
            run_len++;
          end else begin
            run_cls = cls;
            run_len = 1;
          end
        end
        last_rise = cyc;
      end else if (m_active && (cyc - last_rise) >= TO) begin
        m_active = 0;
        run_len = 0;
      end
      m_valid = (run_len >= 2);
      if (m_valid) m_speed = (run_cls == 1);
      s3 = s2; s2 = s1; s1 = led;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_active", active, m_active);
      check("model_valid",  valid,  m_valid);
      check("model_speed",  speed,  m_speed);
      check("model_period", period, m_period);
      check("model_error",  err,    m_error);
    end
  end

  // Pin goes high; returns on the first negedge at which the rise is visible at the outputs
  task automatic start_rise();
    led = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Completes a rise-to-rise interval of p clocks (p >= 4) with a random duty cycle
  task automatic finish_period(input int p);
    int e;
    e = $urandom_range(0, p - 4);
    repeat (e) @(negedge clk);
    led = 1'b0;
    repeat (p - 3 - e) @(negedge clk);
  endtask

  task automatic run_period(input int p);
    finish_period(p);
    start_rise();
  endtask

  initial begin
    int pick, pp;
    repeat (3) @(negedge clk);
    check("rst_active", active, 0);
    check("rst_valid", valid, 0);
    check("rst_period", period, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted mid-count while the pin is toggling
    start_rise();
    run_period(20);
    check("pre_rst_period", period, 20);
    check("pre_rst_active", active, 1);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_active", active, 0);
    check("async_rst_period", period, 0);
    check("async_rst_error", err, 0);
    led = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // First post-reset rise is a reference only; then fast lock
    start_rise();
    check("first_rise_active", active, 1);
    check("first_rise_valid", valid, 0);
    check("first_rise_period", period, 0);
    run_period(20);
    check("fast_rise2_period", period, 20);
    check("fast_rise2_valid", valid, 0);
    run_period(20);
    check("fast_lock_valid", valid, 1);
    check("fast_lock_speed", speed, 1);

    // Tolerance edges
    run_period(25);
    run_period(25);
    check("tol25_valid", valid, 1);
    check("tol25_period", period, 25);
    run_period(26);
    check("tol26_error", err, 1);
    check("tol26_valid", valid, 0);
    run_period(150);
    run_period(150);
    check("tol150_valid", valid, 1);
    check("tol150_speed", speed, 0);
    run_period(149);
    check("tol149_error", err, 1);
    check("tol149_valid", valid, 0);

    // Speed switch fast -> slow
    run_period(20);
    run_period(20);
    check("sw_fast_valid", valid, 1);
    check("sw_fast_speed", speed, 1);
    run_period(200);
    check("sw_first200_valid", valid, 0);
    run_period(200);
    check("sw_second200_valid", valid, 1);
    check("sw_second200_speed", speed, 0);

    // Disable gap: LED held low after a rise until timeout
    led = 1'b0;
    repeat (399) @(negedge clk);
    check("gap399_active", active, 1);
    @(negedge clk);
    check("gap400_active", active, 0);
    check("gap400_valid", valid, 0);
    check("gap400_speed", speed, 0);
    check("gap400_period", period, 200);
    repeat (20) @(negedge clk);
    start_rise();
    check("resume_ref_valid", valid, 0);
    run_period(200);
    check("resume_2_valid", valid, 0);
    run_period(200);
    check("resume_3_valid", valid, 1);
    check("resume_3_speed", speed, 0);

    // Rise on the exact saturation cycle: no timeout, treated as a BAD period
    run_period(400);
    check("race_error", err, 1);
    check("race_active", active, 1);
    check("race_valid", valid, 0);
    check("race_period", period, 400);

    // Randomized periods around and outside both windows
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1: pp = FP;
        2:    pp = $urandom_range(14, 26);
        3, 4: pp = SP;
        5:    pp = $urandom_range(148, 252);
        6:    pp = $urandom_range(4, 300);
        7:    pp = TO;
        8:    pp = $urandom_range(401, 460);
        default: pp = $urandom_range(15, 25);
      endcase
      run_period(pp);
    end
    led = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blink_decoder.md
Name: blink_decoder

Overview:
- Receive-side counterpart of the blinky LED driver: samples an LED drive waveform and recovers the speed setting that produced it (fast or slow), plus whether blinking is present at all.
- Used in self-checking benches and on-board loopback, with a blinky output wired into i_led_drive, to confirm the i_speed/i_enable behaviour without inspecting waveforms by eye.
- Measures rising-edge-to-rising-edge periods in clock cycles.
- Classifies each period against two tolerance windows.
- Locks only after two consecutive agreeing periods.

Parameters:
- FAST_PERIOD, 20000: nominal full blink period in clocks for fast mode.
- SLOW_PERIOD, 200000: nominal full blink period in clocks for slow mode.
- TOL_SHIFT, 3: window half-width = nominal >> TOL_SHIFT (default ±12.5%).
- TIMEOUT, 400000: clocks with no rising edge before blinking is declared absent; must be > SLOW_PERIOD + tolerance.
- CNT_W, 20: period counter width; must hold TIMEOUT.

Ports:
- i_clock, in, 1: system clock, rising edge.
- i_reset, in, 1: asynchronous, active-high reset.
- i_led_drive, in, 1: LED waveform, asynchronous to i_clock.
- o_active, out, 1: a rising edge was seen within the last TIMEOUT clocks.
- o_valid, out, 1: decoder locked; o_speed is meaningful.
- o_speed, out, 1: 1 = fast, 0 = slow (same encoding as blinky i_speed).
- o_period, out, CNT_W: last completed period in clocks.
- o_error, out, 1: one-cycle pulse when a completed period matches neither window.

Behaviour:
- Reset (async assert, sync release): all outputs 0, synchronizer flops 0, counter 0, state IDLE.
- Input path: 2-flop synchronizer, then a third flop for edge detect.
  - A rise is detected 3 rising clock edges after i_led_drive goes high (setup met).
  - Only rising edges are used; duty cycle is ignored.
- Counter:
  - Clears to 1 on the cycle a rise is detected; otherwise increments.
  - Saturates at TIMEOUT.
  - A period equals exactly the number of clocks between two detected rises.
- Classification of period P:
  - FAST if |P − FAST_PERIOD| <= FAST_PERIOD>>TOL_SHIFT.
  - Else SLOW if |P − SLOW_PERIOD| <= SLOW_PERIOD>>TOL_SHIFT.
  - Else BAD.
  - Comparisons are unsigned at CNT_W+1 bits; no wrap.
- States:
  - IDLE: waiting for the first rise. On rise -> ARMED; o_active <= 1.
  - ARMED: one reference rise seen, no prior class.
    - On rise with FAST/SLOW: latch class as candidate -> CONFIRM.
    - On rise with BAD: o_error pulse, stay ARMED.
  - CONFIRM: on next rise:
    - Same class as candidate -> LOCKED; o_valid <= 1, o_speed <= class.
    - Different valid class: candidate <= new class, stay CONFIRM.
    - BAD: o_error, -> ARMED.
  - LOCKED: on each rise:
    - Same class: hold.
    - Other valid class: o_valid <= 0, candidate <= new class -> CONFIRM.
    - BAD: o_error, o_valid <= 0 -> ARMED.
- o_period updates on every detected rise except the first after IDLE. It updates in the same cycle as the state transition.
- Timeout: when the counter reaches TIMEOUT in any state other than IDLE:
  - o_active <= 0, o_valid <= 0 -> IDLE.
  - o_speed and o_period hold their last values.
- Simultaneous timeout and rise in the same cycle: the rise wins and timeout is ignored.
- Blinky disabled mid-pulse (LED forced low): missing or shortened rises produce either BAD periods (o_error, lock dropped) or a timeout. The decoder relocks only after two fresh agreeing periods.
- Reset asserted mid-measurement: immediate return to reset values. The first post-reset rise is only a reference.

Test Plan (use FAST_PERIOD=20, SLOW_PERIOD=200, TOL_SHIFT=2, TIMEOUT=400, CNT_W=10):
- Reset: assert i_reset mid-count with i_led_drive toggling -> all outputs 0 the same cycle; after release, the first rise gives o_active=1, o_valid=0.
- Fast lock: square wave with period 20 clocks -> o_period=20 at rise 2; o_valid=1 and o_speed=1 at rise 3, 3 clocks after the pin edge.
- Tolerance edges: periods 25 then 25 -> lock fast. Period 26 -> o_error pulse, o_valid=0. Periods 150,150 -> lock slow; 149 -> o_error.
- Speed switch: locked fast, then period changes to 200 -> o_valid=0 at the first 200 period, o_valid=1 and o_speed=0 at the second.
- Disable gap: locked slow, LED held low 400 clocks after a rise -> o_active=0, o_valid=0 at count 400, o_speed stays 0. Resume -> relock after 3 rises.
- Race: rise detected on the exact cycle the counter hits 400 -> no timeout; state advances as for a BAD period (o_error=1).
